// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command protocol: command bytes, request
// type encodings, initiator FSM states and the per-type last byte index.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        TYPE_WR      = 2'd0,
        TYPE_RD      = 2'd1,
        TYPE_ALU_OP  = 2'd2,
        TYPE_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef struct packed {
        cmd_type_e   typ;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic [3:0]  fun;
    } cmd_req_t;

    function automatic logic [1:0] lastIdx(input cmd_type_e typ);
        logic [1:0] idx;
        idx = 2'd1;
        case (typ)
            TYPE_WR:     idx = 2'd2;
            TYPE_ALU_OP: idx = 2'd3;
            default:     idx = 2'd1;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_cmd_rsp_timer.sv
// Response timeout counter: cleared on entry to a wait state, counts enabled
// cycles and flags expiry once it sits at TIMEOUT_CYC-1.
module uart_cmd_rsp_timer #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 12
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == LAST);

    // Saturate at the expiry value so a stalled enable can never wrap around.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_initiator.sv
// Host-side UART command initiator: serialises one request into the command
// byte stream and collects the read/ALU response with a per-byte timeout.
module uart_cmd_initiator
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_vld_i,
    input  logic [1:0]  cmd_type_i,
    input  logic [3:0]  cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    input  logic [7:0]  cmd_opa_i,
    input  logic [7:0]  cmd_opb_i,
    input  logic [3:0]  cmd_fun_i,
    output logic        cmd_rdy_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_vld_o,
    input  logic        tx_rdy_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_vld_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_vld_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    cmd_req_t    req_q, req_d;
    cmd_req_t    newReq;
    logic [1:0]  idx_q, idx_d;
    logic        tx_vld_q, tx_vld_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_to_q, rsp_to_d;
    logic        to_flag_q, to_flag_d;
    logic        accept, txFire, lastByte, isAlu;
    logic        tmrClear, tmrEn, tmrExpire;

    function automatic logic [7:0] cmdByte(input cmd_req_t r, input logic [1:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (r.typ)
            TYPE_WR: begin
                case (i)
                    2'd0:    b = CMD_WR;
                    2'd1:    b = {4'h0, r.addr};
                    default: b = r.data;
                endcase
            end
            TYPE_RD:     b = (i == 2'd0) ? CMD_RD : {4'h0, r.addr};
            TYPE_ALU_OP: begin
                case (i)
                    2'd0:    b = CMD_ALU_OP;
                    2'd1:    b = r.opa;
                    2'd2:    b = r.opb;
                    default: b = {4'h0, r.fun};
                endcase
            end
            default:     b = (i == 2'd0) ? CMD_ALU_NOP : {4'h0, r.fun};
        endcase
        return b;
    endfunction

    assign accept    = cmd_vld_i && (state_q == ST_IDLE);
    assign txFire    = tx_vld_q && tx_rdy_i;
    assign lastByte  = (idx_q == lastIdx(req_q.typ));
    assign isAlu     = (req_q.typ == TYPE_ALU_OP) || (req_q.typ == TYPE_ALU_NOP);

    assign newReq.typ  = cmd_type_e'(cmd_type_i);
    assign newReq.addr = cmd_addr_i;
    assign newReq.data = cmd_data_i;
    assign newReq.opa  = cmd_opa_i;
    assign newReq.opb  = cmd_opb_i;
    assign newReq.fun  = cmd_fun_i;

    uart_cmd_rsp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (tmrClear),
        .en_i     (tmrEn),
        .expire_o (tmrExpire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_SEND;
            ST_SEND:    if (txFire && lastByte)
                            state_d = (req_q.typ == TYPE_WR) ? ST_DONE : ST_WAIT_LO;
            ST_WAIT_LO: if (rx_vld_i) state_d = isAlu ? ST_WAIT_HI : ST_DONE;
                        else if (tmrExpire) state_d = ST_DONE;
            ST_WAIT_HI: if (rx_vld_i || tmrExpire) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d      = req_q;
        idx_d      = idx_q;
        tx_vld_d   = tx_vld_q;
        tx_data_d  = tx_data_q;
        rsp_data_d = rsp_data_q;
        to_flag_d  = to_flag_q;
        rsp_vld_d  = (state_q == ST_DONE);
        rsp_to_d   = (state_q == ST_DONE) && to_flag_q;
        tmrClear   = 1'b0;
        tmrEn      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d      = newReq;
                    idx_d      = 2'd0;
                    tx_vld_d   = 1'b1;
                    tx_data_d  = cmdByte(newReq, 2'd0);
                    rsp_data_d = '0;
                    to_flag_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (txFire) begin
                    if (lastByte) begin
                        tx_vld_d  = 1'b0;
                        tx_data_d = '0;
                        tmrClear  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = cmdByte(req_q, idx_q + 2'd1);
                    end
                end
            end
            ST_WAIT_LO: begin
                tmrEn = !rx_vld_i;
                if (rx_vld_i) begin
                    rsp_data_d[7:0] = rx_data_i;
                    tmrClear        = 1'b1;
                end else if (tmrExpire) begin
                    to_flag_d = 1'b1;
                end
            end
            ST_WAIT_HI: begin
                tmrEn = !rx_vld_i;
                if (rx_vld_i) begin
                    rsp_data_d[15:8] = rx_data_i;
                end else if (tmrExpire) begin
                    to_flag_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= '0;
            idx_q      <= '0;
            tx_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
            to_flag_q  <= 1'b0;
        end else begin
            req_q      <= req_d;
            idx_q      <= idx_d;
            tx_vld_q   <= tx_vld_d;
            tx_data_q  <= tx_data_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_to_q   <= rsp_to_d;
            to_flag_q  <= to_flag_d;
        end
    end

    assign cmd_rdy_o     = (state_q == ST_IDLE);
    assign busy_o        = !cmd_rdy_o;
    assign tx_vld_o      = tx_vld_q;
    assign tx_data_o     = tx_data_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Self-checking bench for uart_cmd_initiator: directed protocol cases plus
// randomized commands checked against a byte-list/timing reference model.
module tb_uart_cmd_initiator;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_vld_i;
    logic [1:0]  cmd_type_i;
    logic [3:0]  cmd_addr_i;
    logic [7:0]  cmd_data_i;
    logic [7:0]  cmd_opa_i;
    logic [7:0]  cmd_opb_i;
    logic [3:0]  cmd_fun_i;
    logic        cmd_rdy_o;
    logic [7:0]  tx_data_o;
    logic        tx_vld_o;
    logic        tx_rdy_i;
    logic [7:0]  rx_data_i;
    logic        rx_vld_i;
    logic [15:0] rsp_data_o;
    logic        rsp_vld_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    uart_cmd_initiator #(.TIMEOUT_CYC(T), .TO_W(6)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cmd_vld_i     (cmd_vld_i),
        .cmd_type_i    (cmd_type_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_data_i    (cmd_data_i),
        .cmd_opa_i     (cmd_opa_i),
        .cmd_opb_i     (cmd_opb_i),
        .cmd_fun_i     (cmd_fun_i),
        .cmd_rdy_o     (cmd_rdy_o),
        .tx_data_o     (tx_data_o),
        .tx_vld_o      (tx_vld_o),
        .tx_rdy_i      (tx_rdy_i),
        .rx_data_i     (rx_data_i),
        .rx_vld_i      (rx_vld_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_vld_o     (rsp_vld_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_rdy"}, cmd_rdy_o, 1);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_tx_vld"}, tx_vld_o, 0);
        checkOutput({tag, "_tx_data"}, tx_data_o, 0);
        checkOutput({tag, "_rsp_vld"}, rsp_vld_o, 0);
        checkOutput({tag, "_rsp_to"}, rsp_timeout_o, 0);
        checkOutput({tag, "_rsp_data"}, rsp_data_o, 0);
    endtask

    // One full command: drive request, play TX_RDY pattern and RX schedule,
    // compare against the expected byte list, response value and completion cycle.
    task automatic applyStimulus(input int typ, input logic [3:0] addr, input logic [7:0] data,
                                 input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                                 input int rdyMode, input int d0, input int d1,
                                 input logic [7:0] r0, input logic [7:0] r1,
                                 input bit echo, input bit abortHi);
        logic [7:0]  txExp[$];
        int          delays[2];
        logic [7:0]  rbytes[2];
        int          nResp, txSeen, rxIdx, waitStart, expRspCycle, rspCycle;
        bit          accepted, done, timedOut, expTo, prevVld, prevFire;
        logic [7:0]  prevData;
        logic [15:0] expData;
        logic [15:0] gotData;
        logic        gotTo;

        delays[0] = d0; delays[1] = d1;
        rbytes[0] = r0; rbytes[1] = r1;
        case (typ)
            0: begin txExp.push_back(8'hAA); txExp.push_back({4'h0, addr}); txExp.push_back(data); nResp = 0; end
            1: begin txExp.push_back(8'hBB); txExp.push_back({4'h0, addr}); nResp = 1; end
            2: begin txExp.push_back(8'hCC); txExp.push_back(opa); txExp.push_back(opb);
                     txExp.push_back({4'h0, fun}); nResp = 2; end
            default: begin txExp.push_back(8'hDD); txExp.push_back({4'h0, fun}); nResp = 2; end
        endcase
        txSeen = 0; rxIdx = 0; waitStart = -1; expRspCycle = -1; rspCycle = -1;
        accepted = 0; done = 0; timedOut = 0; expTo = 0; prevVld = 0; prevFire = 0;
        prevData = '0; expData = '0; gotData = '0; gotTo = 0;

        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (rsp_vld_o) begin
                done = 1; rspCycle = cyc; gotData = rsp_data_o; gotTo = rsp_timeout_o;
                checkOutput("rsp_cmd_rdy", cmd_rdy_o, 1);
            end
            case (rdyMode)
                0:       tx_rdy_i = 1'b1;
                1:       tx_rdy_i = ((cyc % 3) == 0);
                default: tx_rdy_i = 1'($urandom_range(0, 1));
            endcase
            if (!accepted) begin
                cmd_vld_i = 1'b1; cmd_type_i = 2'(typ); cmd_addr_i = addr; cmd_data_i = data;
                cmd_opa_i = opa; cmd_opb_i = opb; cmd_fun_i = fun;
                if (cmd_rdy_o) accepted = 1;
            end else begin
                cmd_vld_i  = cmd_rdy_o ? 1'b0 : 1'($urandom_range(0, 1));
                cmd_type_i = 2'($urandom); cmd_addr_i = 4'($urandom); cmd_data_i = 8'($urandom);
                cmd_opa_i  = 8'($urandom); cmd_opb_i = 8'($urandom); cmd_fun_i = 4'($urandom);
                checkOutput("busy_inv", busy_o, !cmd_rdy_o);
            end
            if (prevVld && !prevFire) begin
                checkOutput("tx_hold_vld", tx_vld_o, 1);
                checkOutput("tx_hold_data", tx_data_o, prevData);
            end
            if (tx_vld_o && tx_rdy_i) begin
                if (txSeen < txExp.size()) checkOutput($sformatf("tx_byte%0d", txSeen), tx_data_o, txExp[txSeen]);
                else checkOutput("tx_count_over", txSeen + 1, txExp.size());
                txSeen++;
                if (txSeen == txExp.size()) begin
                    waitStart = cyc + 1;
                    if (nResp == 0) expRspCycle = cyc + 2;
                    else if (delays[0] >= T) begin timedOut = 1; expTo = 1; expRspCycle = waitStart + T + 1; end
                end
            end
            prevVld = tx_vld_o; prevFire = tx_vld_o && tx_rdy_i; prevData = tx_data_o;

            rx_vld_i = 1'b0; rx_data_i = 8'($urandom);
            if (echo && accepted && txSeen < txExp.size() && $urandom_range(0, 1) == 1) begin
                rx_vld_i = 1'b1; rx_data_i = 8'h55;
            end else if (waitStart >= 0 && rxIdx < nResp && !timedOut && cyc == waitStart + delays[rxIdx]) begin
                rx_vld_i = 1'b1; rx_data_i = rbytes[rxIdx];
                if (rxIdx == 0) expData[7:0] = rbytes[0]; else expData[15:8] = rbytes[1];
                rxIdx++;
                waitStart = cyc + 1;
                if (rxIdx == nResp) expRspCycle = cyc + 2;
                else if (delays[rxIdx] >= T) begin timedOut = 1; expTo = 1; expRspCycle = waitStart + T + 1; end
            end

            if (abortHi && rxIdx == 1 && cyc == waitStart + 2) begin
                rst_ni = 1'b0;
                cmd_vld_i = 1'b0; rx_vld_i = 1'b0;
                #1;
                checkResetOutputs("abort");
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("abort_no_rsp", rsp_vld_o, 0);
                end
                rst_ni = 1'b1;
                @(negedge clk);
                checkOutput("abort_idle", cmd_rdy_o, 1);
                return;
            end
        end
        cmd_vld_i = 1'b0; rx_vld_i = 1'b0;

        checkOutput("rsp_seen", done, 1);
        checkOutput("tx_count", txSeen, txExp.size());
        checkOutput("rsp_data", gotData, expData);
        checkOutput("rsp_timeout", gotTo, expTo);
        checkOutput("rsp_cycle", rspCycle, expRspCycle);
        @(negedge clk);
        checkOutput("rsp_one_cycle", rsp_vld_o, 0);
        checkOutput("post_cmd_rdy", cmd_rdy_o, 1);
    endtask

    initial begin
        int typ, d0, d1;
        rst_ni = 1'b0; cmd_vld_i = 0; cmd_type_i = 0; cmd_addr_i = 0; cmd_data_i = 0;
        cmd_opa_i = 0; cmd_opb_i = 0; cmd_fun_i = 0; tx_rdy_i = 0; rx_data_i = 0; rx_vld_i = 0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_ni = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        applyStimulus(1, 4'd2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 10, 0, 8'h7E, 8'h00, 0, 0);
        applyStimulus(2, 4'd0, 8'h00, 8'h12, 8'h34, 4'h0, 1, 3, 2, 8'h46, 8'h00, 0, 0);
        applyStimulus(3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h2, 0, 4, T + 10, 8'h10, 8'h00, 0, 0);
        applyStimulus(1, 4'd9, 8'h00, 8'h00, 8'h00, 4'h0, 1, 5, 0, 8'h99, 8'h00, 1, 0);
        applyStimulus(1, 4'd3, 8'h00, 8'h00, 8'h00, 4'h0, 0, T - 1, 0, 8'hA5, 8'h00, 0, 0);
        applyStimulus(2, 4'd0, 8'h00, 8'h01, 8'h02, 4'h7, 0, 0, T - 1, 8'h5A, 8'hC3, 0, 0);
        applyStimulus(1, 4'd4, 8'h00, 8'h00, 8'h00, 4'h0, 0, T, 0, 8'h11, 8'h00, 0, 0);
        applyStimulus(2, 4'd0, 8'h00, 8'hF0, 8'h0F, 4'h1, 0, 2, 40, 8'h77, 8'h88, 0, 1);
        applyStimulus(0, 4'd15, 8'hE1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00, 8'h00, 0, 0);

        $display("[TB] randomized cases");
        for (int n = 0; n < 30; n++) begin
            typ = $urandom_range(0, 3);
            d0 = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 12);
            d1 = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 12);
            applyStimulus(typ, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                          $urandom_range(0, 2), d0, d1, 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_cmd_initiator.md
Name: uart_cmd_initiator

Overview:
- Host-side initiator for the system's UART command protocol.
- Accepts one parallel command request and serialises it into the command byte stream: AA write, BB read, CC ALU with operands, DD ALU without operands.
- Collects the response bytes returned by the system (read data, or a 16-bit ALU result) and reports them upstream with a timeout guard.
- Sits between a UART TX/RX pair and a local requester: BIST master, loopback host or emulation harness.

Parameters:
TIMEOUT_CYC, 4096, cycles to wait for each response byte before aborting
TO_W, 12, width of timeout counter (clog2 of TIMEOUT_CYC)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
CMD_VLD  in  1  command request valid
CMD_TYPE  in  2  0=WR(AA) 1=RD(BB) 2=ALU_OP(CC) 3=ALU_NOP(DD)
CMD_ADDR  in  4  register-file address (WR/RD)
CMD_DATA  in  8  write data (WR)
CMD_OPA  in  8  operand A (ALU_OP)
CMD_OPB  in  8  operand B (ALU_OP)
CMD_FUN  in  4  ALU function (ALU_OP/ALU_NOP)
CMD_RDY  out  1  initiator idle, request accepted when CMD_VLD&CMD_RDY
TX_DATA  out  8  byte to UART transmitter
TX_VLD  out  1  byte valid
TX_RDY  in  1  transmitter can take a byte
RX_DATA  in  8  byte from UART receiver
RX_VLD  in  1  one-cycle strobe, RX_DATA valid
RSP_DATA  out  16  response payload
RSP_VLD  out  1  one-cycle strobe, command completed
RSP_TIMEOUT  out  1  qualifies RSP_VLD: response not received in time
BUSY  out  1  inverse of CMD_RDY

Behaviour:
- Reset values: CMD_RDY=1, BUSY=0, TX_VLD=0, TX_DATA=0, RSP_VLD=0, RSP_TIMEOUT=0, RSP_DATA=0. All request fields are cleared. FSM returns to IDLE.
- Reset mid-operation aborts the command immediately. No partial response is produced.
- On accept, all request fields are registered. Later changes on the CMD_* inputs are ignored until the next accept.
- Byte sequences:
  - WR: AA, {0,ADDR}, DATA
  - RD: BB, {0,ADDR}
  - ALU_OP: CC, OPA, OPB, {0,FUN}
  - ALU_NOP: DD, {0,FUN}
- FSM states: IDLE, SEND (byte index 0..3), WAIT_LO, WAIT_HI, DONE.
- IDLE -> SEND on accept. The first TX_VLD appears the cycle after accept.
- SEND handshake:
  - TX_VLD and TX_DATA are registered and held stable until TX_VLD&TX_RDY.
  - A byte transfers on each cycle where TX_VLD&TX_RDY; the next byte is presented the following cycle. One-cycle gaps between bytes are permitted.
  - After the last byte: WR -> DONE; RD -> WAIT_LO; ALU_OP/ALU_NOP -> WAIT_LO.
- Response waits:
  - WAIT_LO: the first RX_VLD loads RSP_DATA[7:0]. RD -> DONE, with RSP_DATA[15:8]=0. ALU -> WAIT_HI.
  - WAIT_HI: the next RX_VLD loads RSP_DATA[15:8] and goes to DONE.
  - Response byte order is LSB first.
- RX_VLD outside the WAIT states is ignored. This includes RX_VLD during SEND, where echo or stale bytes are dropped.
- Timeout:
  - The counter clears on entry to each WAIT state and increments every cycle without RX_VLD.
  - At TIMEOUT_CYC-1 the FSM goes to DONE with RSP_TIMEOUT=1, and RSP_DATA holds whatever bytes were captured.
  - RX_VLD on the same cycle as expiry wins: the byte is taken and there is no timeout.
- DONE:
  - RSP_VLD=1 for exactly one cycle, then IDLE with CMD_RDY=1 the next cycle.
  - WR completion also pulses RSP_VLD, with RSP_DATA=0 and RSP_TIMEOUT=0.
- Latency with TX_RDY tied high:
  - WR: RSP_VLD 5 cycles after accept.
  - RD and ALU: counted from the final required RX_VLD, RSP_VLD fires 2 cycles later.
- CMD_VLD while busy is not accepted. The requester holds it.

Decomposition:
- Shared package uart_cmd_pkg:
  - command byte constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - CMD_TYPE encodings
  - FSM state encoding
  - The system-side controller reuses the command byte constants.
- One natural sub-module, uart_cmd_rsp_timer: loadable timeout counter with clear/enable/expire.
- The byte multiplexer stays inline.

Test Plan:
- WR addr=5 data=0x3C, TX_RDY=1 -> TX bytes AA,05,3C; RSP_VLD one cycle, RSP_DATA=0, RSP_TIMEOUT=0; CMD_RDY high next cycle.
- RD addr=2, then RX_VLD with 0x7E after 10 cycles -> TX bytes BB,02; RSP_DATA=0x007E, RSP_TIMEOUT=0.
- ALU_OP A=0x12 B=0x34 FUN=0 with TX_RDY toggling 1 cycle on / 2 cycles off -> TX bytes CC,12,34,00, each byte held stable until accepted; RX bytes 0x46,0x00 -> RSP_DATA=0x0046.
- ALU_NOP FUN=2, RX 0x10, then no second byte -> TX bytes DD,02; after TIMEOUT_CYC cycles RSP_VLD=1, RSP_TIMEOUT=1, RSP_DATA[7:0]=0x10.
- RX_VLD with 0x55 pulsed during SEND of an RD, then RX 0x99 -> 0x55 ignored, RSP_DATA=0x0099; RX_VLD on the expiry cycle -> byte captured, RSP_TIMEOUT=0.
- Assert RST during WAIT_HI -> all outputs return to reset values immediately, no RSP_VLD; a new WR is accepted after release.
